// File: rtl/jtframe_romarb.sv
`default_nettype none
// jtframe_romarb -- arbitrates per-slot ROM reads onto one SDRAM read port,
// keeping a one-entry (valid/tag/data) cache per slot.  Rev 1.0
module jtframe_romarb #(
   parameter int                  SLOTS   = 4,
   parameter int                  AW      = 18,
   parameter logic [SLOTS*22-1:0] OFFSETS = '0,
   parameter logic [SLOTS-1:0]    DW32    = '0,
   parameter int                  RR      = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  downloading,
   input  logic [SLOTS-1:0]      slot_cs,
   input  logic [SLOTS*AW-1:0]   slot_addr,
   output logic [SLOTS-1:0]      slot_ok,
   output logic [SLOTS*32-1:0]   slot_dout,
   output logic                  sdram_req,
   output logic [21:0]           sdram_addr,
   input  logic                  sdram_ack,
   input  logic                  data_rdy,
   input  logic [31:0]           data_read,
   output logic                  refresh_en
);
   localparam int            IW        = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam logic [IW-1:0] LAST_SLOT = IW'(SLOTS - 1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_ACK  = 2'd1,
      ST_WAIT_DATA = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            req_q, req_d;
   logic [21:0]     addr_q, addr_d;
   logic [IW-1:0]   gnt_q, gnt_d;
   logic [IW-1:0]   last_q, last_d;
   logic            drop_q, drop_d;
   logic            fill;

   logic [SLOTS-1:0] valid_q;
   logic [21:0]      tag_q  [SLOTS];
   logic [31:0]      data_q [SLOTS];
   logic [21:0]      waddr  [SLOTS];
   logic [SLOTS-1:0] hit;
   logic [SLOTS-1:0] pend;
   logic             win_found;
   logic [IW-1:0]    win_idx;

   // 8-bit slots keep the whole 16-bit word so both bytes hit the same entry.
   for (genvar i = 0; i < SLOTS; i++) begin : g_slot
      logic [AW-1:0] a;
      logic [21:0]   off;
      assign a   = slot_addr[i*AW +: AW];
      assign off = OFFSETS[i*22 +: 22];
      if (DW32[i]) begin : g_dw32
         assign waddr[i]              = off + 22'({a, 1'b0});
         assign slot_dout[i*32 +: 32] = data_q[i];
      end else begin : g_dw8
         assign waddr[i]              = off + 22'(a[AW-1:1]);
         assign slot_dout[i*32 +: 32] = {24'd0, a[0] ? data_q[i][15:8] : data_q[i][7:0]};
      end
      assign hit[i]     = valid_q[i] && (tag_q[i] == waddr[i]);
      assign pend[i]    = slot_cs[i] && !hit[i];
      assign slot_ok[i] = slot_cs[i] && hit[i] && !downloading;
   end

   always_comb begin
      int j;
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < SLOTS; k++) begin
         j = k;
         if (RR != 0) begin
            j = int'(last_q) + 1 + k;
            if (j >= SLOTS) j = j - SLOTS;
         end
         if (!win_found && pend[j]) begin
            win_found = 1'b1;
            win_idx   = IW'(j);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      addr_d  = addr_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      drop_d  = drop_q | downloading;
      fill    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            drop_d = 1'b0;
            if (win_found && !downloading) begin
               state_d = ST_WAIT_ACK;
               req_d   = 1'b1;
               addr_d  = waddr[win_idx];
               gnt_d   = win_idx;
               last_d  = win_idx;
            end
         end
         ST_WAIT_ACK: begin
            // A data_rdy coinciding with the ack belongs to no request of ours.
            if (sdram_ack) begin
               req_d   = 1'b0;
               state_d = ST_WAIT_DATA;
            end
         end
         ST_WAIT_DATA: begin
            if (data_rdy) begin
               fill    = !drop_d;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         req_q   <= 1'b0;
         addr_q  <= '0;
         gnt_q   <= '0;
         last_q  <= LAST_SLOT;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         drop_q  <= drop_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < SLOTS; i++) begin
            tag_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else if (downloading) begin
         valid_q <= '0;
      end else if (fill) begin
         valid_q[gnt_q] <= 1'b1;
         tag_q[gnt_q]   <= addr_q;
         data_q[gnt_q]  <= data_read;
      end
   end

   assign sdram_req  = req_q;
   assign sdram_addr = addr_q;
   assign refresh_en = rst || downloading || ((state_q == ST_IDLE) && (pend == '0));

endmodule
`default_nettype wire

// File: tb/tb_jtframe_romarb.sv
`default_nettype none
// tb_jtframe_romarb -- random and directed stimulus against a transaction-level
// model of the slot caches and the SDRAM request protocol.
module tb_jtframe_romarb;
   localparam logic [21:0] OFF [4] = '{22'h00000, 22'h14000, 22'h20000, 22'h30000};
   localparam logic [3:0]  DW      = 4'b0100;
   localparam logic [87:0] OFFP    = {22'h30000, 22'h20000, 22'h14000, 22'h00000};

   logic         clk = 1'b0;
   logic         rst, downloading;
   logic [3:0]   slot_cs;
   logic [71:0]  slot_addr;
   logic [3:0]   slot_ok;
   logic [127:0] slot_dout;
   logic         sdram_req, sdram_ack, data_rdy, refresh_en;
   logic [21:0]  sdram_addr;
   logic [31:0]  data_read;

   logic         b_rst, b_dl, b_req, b_ack, b_rdy, b_refresh;
   logic [3:0]   b_cs, b_ok;
   logic [71:0]  b_addr;
   logic [127:0] b_dout;
   logic [21:0]  b_saddr;
   logic [31:0]  b_data;

   always #5 clk = ~clk;

   jtframe_romarb #(.SLOTS(4), .AW(18), .OFFSETS(OFFP), .DW32(DW), .RR(0)) u_fix (
      .clk(clk), .rst(rst), .downloading(downloading), .slot_cs(slot_cs),
      .slot_addr(slot_addr), .slot_ok(slot_ok), .slot_dout(slot_dout),
      .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
      .data_rdy(data_rdy), .data_read(data_read), .refresh_en(refresh_en));

   jtframe_romarb #(.SLOTS(4), .AW(18), .OFFSETS(OFFP), .DW32(DW), .RR(1)) u_rr (
      .clk(clk), .rst(b_rst), .downloading(b_dl), .slot_cs(b_cs),
      .slot_addr(b_addr), .slot_ok(b_ok), .slot_dout(b_dout),
      .sdram_req(b_req), .sdram_addr(b_saddr), .sdram_ack(b_ack),
      .data_rdy(b_rdy), .data_read(b_data), .refresh_en(b_refresh));

   int n_chk = 0;
   int n_err = 0;

   // transaction-level model state
   bit          m_busy, m_acked, m_drop;
   int          m_gnt;
   logic [21:0] m_waddr;
   bit          m_valid [4];
   logic [21:0] m_tag   [4];
   logic [31:0] m_data  [4];

   bit drv_en;
   int drv_phase, drv_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [21:0] exp_waddr(input int i, input logic [17:0] a);
      int unsigned w;
      w = int'(OFF[i]) + (DW[i] ? int'(a) * 2 : int'(a) / 2);
      return w[21:0];
   endfunction

   task automatic model_reset();
      m_busy = 0; m_acked = 0; m_drop = 0; m_gnt = 0; m_waddr = '0;
      for (int i = 0; i < 4; i++) begin
         m_valid[i] = 0; m_tag[i] = '0; m_data[i] = '0;
      end
      drv_phase = 0; drv_cnt = 0;
   endtask

   function automatic bit m_hit(input int i);
      return m_valid[i] && (m_tag[i] == exp_waddr(i, slot_addr[i*18 +: 18]));
   endfunction

   // Predicts the effect of the coming clock edge from the inputs now applied.
   task automatic model_step();
      int w;
      w = -1;
      for (int i = 3; i >= 0; i--)
         if (slot_cs[i] && !m_hit(i)) w = i;
      if (!m_busy) begin
         if (w >= 0 && !downloading) begin
            m_busy = 1; m_acked = 0; m_drop = 0; m_gnt = w;
            m_waddr = exp_waddr(w, slot_addr[w*18 +: 18]);
         end
      end else if (!m_acked) begin
         m_drop = m_drop | downloading;
         if (sdram_ack) m_acked = 1;
      end else begin
         m_drop = m_drop | downloading;
         if (data_rdy) begin
            if (!m_drop) begin
               m_valid[m_gnt] = 1; m_tag[m_gnt] = m_waddr; m_data[m_gnt] = data_read;
            end
            m_busy = 0;
         end
      end
      if (downloading)
         for (int i = 0; i < 4; i++) m_valid[i] = 0;
   endtask

   task automatic check_all();
      logic [17:0] a;
      logic [31:0] ed;
      bit any;
      any = 0;
      for (int i = 0; i < 4; i++) begin
         a = slot_addr[i*18 +: 18];
         if (slot_cs[i] && !m_hit(i)) any = 1;
         chk($sformatf("ok%0d", i), 32'(slot_ok[i]), 32'(slot_cs[i] && m_hit(i) && !downloading));
         ed = DW[i] ? m_data[i] : (a[0] ? {24'h0, m_data[i][15:8]} : {24'h0, m_data[i][7:0]});
         chk($sformatf("dout%0d", i), slot_dout[i*32 +: 32], ed);
      end
      chk("req", 32'(sdram_req), 32'(m_busy && !m_acked));
      if (m_busy && !m_acked) chk("addr", 32'(sdram_addr), 32'(m_waddr));
      chk("refresh", 32'(refresh_en), 32'((!m_busy && !any) || downloading));
   endtask

   task automatic drive_sdram();
      sdram_ack = 1'b0; data_rdy = 1'b0; data_read = $urandom;
      if (drv_phase == 0) begin
         if (sdram_req && $urandom_range(1, 0) == 1) begin
            sdram_ack = 1'b1;
            data_rdy  = ($urandom_range(3, 0) == 0);
            drv_cnt   = $urandom_range(2, 0);
            drv_phase = 1;
         end
      end else if (drv_cnt == 0) begin
         data_rdy  = 1'b1;
         drv_phase = 0;
      end else begin
         drv_cnt--;
      end
   endtask

   task automatic tick();
      model_step();
      @(negedge clk);
      check_all();
      if (drv_en) drive_sdram();
   endtask

   task automatic wait_req(input string tag);
      int k;
      k = 0;
      while (!sdram_req && k < 20) begin tick(); k++; end
      if (!sdram_req) chk(tag, 32'(sdram_req), 32'd1);
   endtask

   task automatic serve_a(input logic [31:0] d);
      sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
      data_rdy = 1'b1; data_read = d; tick(); data_rdy = 1'b0;
   endtask

   task automatic drain();
      int k;
      slot_cs = '0; downloading = 1'b0; drv_en = 1; k = 0;
      while (m_busy && k < 60) begin tick(); k++; end
      chk("drain_idle", 32'(m_busy), 32'd0);
      drv_en = 0; sdram_ack = 1'b0; data_rdy = 1'b0;
   endtask

   task automatic b_wait(input string tag);
      int k;
      k = 0;
      while (!b_req && k < 20) begin @(negedge clk); k++; end
      if (!b_req) chk(tag, 32'(b_req), 32'd1);
   endtask

   task automatic b_serve();
      b_ack = 1'b1; @(negedge clk); b_ack = 1'b0;
      b_rdy = 1'b1; @(negedge clk); b_rdy = 1'b0;
   endtask

   initial begin
      int k;
      rst = 1'b1; b_rst = 1'b1; downloading = 1'b0; b_dl = 1'b0;
      slot_cs = '0; slot_addr = '0; sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
      b_cs = '0; b_addr = '0; b_ack = 1'b0; b_rdy = 1'b0; b_data = 32'h0000_0011;
      drv_en = 0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_req", 32'(sdram_req), 32'd0);
      chk("rst_addr", 32'(sdram_addr), 32'd0);
      chk("rst_ok", 32'(slot_ok), 32'd0);
      chk("rst_refresh", 32'(refresh_en), 32'd1);
      for (int i = 0; i < 4; i++) chk("rst_dout", slot_dout[i*32 +: 32], 32'd0);
      rst = 1'b0; b_rst = 1'b0;

      // round-robin instance: pointer starts at the last slot
      b_cs = 4'b0101; b_addr[0 +: 18] = 18'h10; b_addr[36 +: 18] = 18'h5;
      b_wait("rr_first_to");
      chk("rr_first", 32'(b_saddr), 32'h8);
      b_ack = 1'b1; @(negedge clk); b_ack = 1'b0;
      b_rdy = 1'b1; b_addr[0 +: 18] = 18'h20; @(negedge clk); b_rdy = 1'b0;
      b_wait("rr_next_to");
      chk("rr_next", 32'(b_saddr), 32'h2000A);
      b_serve();
      b_wait("rr_wrap_to");
      chk("rr_wrap", 32'(b_saddr), 32'h10);
      b_serve();
      chk("rr_ok", 32'(b_ok), 32'h5);

      // randomized traffic on the fixed-priority instance
      drv_en = 1;
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(7, 0) == 0) slot_cs[i] = ~slot_cs[i];
            if ($urandom_range(7, 0) == 0) slot_addr[i*18 +: 18] = 18'h100 + 18'($urandom_range(5, 0));
         end
         downloading = ($urandom_range(63, 0) == 0);
         tick();
      end
      drain();

      // byte fetch from an offset 8-bit slot, then repeated hits
      slot_cs = 4'b0010; slot_addr[18 +: 18] = 18'h3;
      wait_req("s1_req_to");
      chk("s1_addr", 32'(sdram_addr), 32'h14001);
      sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
      data_rdy = 1'b1; data_read = 32'h1234_ABCD;
      chk("s1_ok_before", 32'(slot_ok[1]), 32'd0);
      tick(); data_rdy = 1'b0;
      chk("s1_ok", 32'(slot_ok[1]), 32'd1);
      chk("s1_dout", slot_dout[63:32], 32'h0000_00AB);
      for (int n = 0; n < 8; n++) begin
         tick();
         chk("hit_noreq", 32'(sdram_req), 32'd0);
         chk("hit_refresh", 32'(refresh_en), 32'd1);
         chk("hit_ok", 32'(slot_ok[1]), 32'd1);
      end

      // download pulse invalidates the cache
      downloading = 1'b1; tick(); downloading = 1'b0;
      tick();
      chk("dl_ok", 32'(slot_ok[1]), 32'd0);
      wait_req("dl_req_to");
      chk("dl_refetch", 32'(sdram_addr), 32'h14001);
      drv_en = 1; k = 0;
      while (!slot_ok[1] && k < 30) begin tick(); k++; end
      chk("dl_refill_ok", 32'(slot_ok[1]), 32'd1);
      drain();

      // address changes while the fetch is in flight
      slot_cs = 4'b1000; slot_addr[54 +: 18] = 18'h2000;
      wait_req("mv_req_to");
      chk("mv_addr1", 32'(sdram_addr), 32'h31000);
      sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
      slot_addr[54 +: 18] = 18'h2400; tick();
      data_rdy = 1'b1; data_read = 32'h5566_7788; tick(); data_rdy = 1'b0;
      chk("mv_ok_low", 32'(slot_ok[3]), 32'd0);
      wait_req("mv_req2_to");
      chk("mv_addr2", 32'(sdram_addr), 32'h31200);
      serve_a(32'h0000_99AA);
      chk("mv_ok", 32'(slot_ok[3]), 32'd1);
      chk("mv_dout", slot_dout[127:96], 32'h0000_00AA);
      drain();

      // fixed priority: lowest pending index first
      slot_cs = 4'b0101; slot_addr[0 +: 18] = 18'h2000; slot_addr[36 +: 18] = 18'h3000;
      wait_req("fp_req_to");
      chk("fp_first", 32'(sdram_addr), 32'h01000);
      serve_a(32'hCAFE_0001);
      wait_req("fp_req2_to");
      chk("fp_second", 32'(sdram_addr), 32'h26000);
      serve_a(32'hCAFE_0002);
      chk("fp_ok", 32'(slot_ok), 32'h5);
      drain();

      // reset during WAIT_ACK, then a stray data_rdy in IDLE
      slot_cs = 4'b0001; slot_addr[0 +: 18] = 18'h3;
      wait_req("ra_req_to");
      #2 rst = 1'b1;
      #1 chk("ra_req_async", 32'(sdram_req), 32'd0);
      chk("ra_ok", 32'(slot_ok), 32'd0);
      slot_cs = '0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      data_rdy = 1'b1; data_read = 32'hDEAD_BEEF;
      tick(); data_rdy = 1'b0;
      slot_cs = 4'b0001; slot_addr[0 +: 18] = 18'h1;
      #1 chk("ra_late_ok", 32'(slot_ok), 32'd0);
      tick();
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/jtframe_romarb.md
JTFRAME_ROMARB -- requirements
Module: jtframe_romarb

Interface
REQ-001 Parameter SLOTS, default 4: number of ROM client slots, legal range 1..8.
REQ-002 Parameter AW, default 18: address width of every slot, legal range 8..22.
REQ-003 Parameter OFFSETS, default 0: packed SLOTS*22-bit field; field i is the SDRAM word offset of slot i.
REQ-004 Parameter DW32, default 0: SLOTS-bit mask; bit i=1 means slot i is a 32-bit slot, bit i=0 means an 8-bit slot.
REQ-005 Parameter RR, default 0: 0 selects fixed priority (lowest index wins), 1 selects round-robin.
REQ-006 Port clk, input, 1: system clock; the block uses only this clock.
REQ-007 Port rst, input, 1: reset, asynchronous and active-high.
REQ-008 Port downloading, input, 1: ROM download in progress.
REQ-009 Port slot_cs, input, SLOTS: per-slot read request.
REQ-010 Port slot_addr, input, SLOTS*AW: packed per-slot address.
REQ-011 Port slot_ok, output, SLOTS: per-slot data valid.
REQ-012 Port slot_dout, output, SLOTS*32: packed per-slot read data.
REQ-013 Port sdram_req, output, 1: SDRAM read request.
REQ-014 Port sdram_addr, output, 22: SDRAM 16-bit word address.
REQ-015 Port sdram_ack, input, 1: SDRAM has accepted the request.
REQ-016 Port data_rdy, input, 1: data_read is valid.
REQ-017 Port data_read, input, 32: SDRAM read data.
REQ-018 Port refresh_en, output, 1: SDRAM auto-refresh permitted.

Function
REQ-019 Word address, 8-bit slot: OFFSETS[i] + addr[AW-1:1]; byte select: addr[0] ? data[15:8] : data[7:0], zero-extended to 32 bits.
REQ-020 Word address, 32-bit slot: OFFSETS[i] + (addr<<1), truncated to 22 bits; dout is the full 32-bit data.
REQ-021 Each slot has a one-entry cache holding valid, 22-bit tag and 32-bit data.
REQ-022 slot_ok[i] is combinational: cs[i] & valid[i] & (tag[i]==word address[i]) & ~downloading.
REQ-023 slot_dout[i] is driven from the cache data at all times, whether or not slot_ok is set.
REQ-024 A slot is pending when cs[i]=1 and it misses its cache.
REQ-025 State machine has three states: IDLE, WAIT_ACK, WAIT_DATA.
REQ-026 IDLE, when any slot is pending and downloading=0: the arbiter picks a winner, registers its index and word address, sets sdram_req=1, and moves to WAIT_ACK on the next clock.
REQ-027 Fixed priority: the lowest pending index wins.
REQ-028 Round-robin: the first pending index strictly after the last granted index wins, wrapping from SLOTS-1 to 0.
REQ-029 WAIT_ACK: sdram_req and sdram_addr stay stable until sdram_ack=1; sdram_req then drops on the next clock and the state moves to WAIT_DATA.
REQ-030 WAIT_DATA: on data_rdy=1 the cache of the granted slot is written (valid=1, tag, data) and the state returns to IDLE.
REQ-031 slot_ok for the granted slot rises one clock after data_rdy, provided cs and the address are unchanged.
REQ-032 If the slot address changes while its request is in flight, the fetch still completes and fills the cache; slot_ok stays low and the slot re-requests from IDLE.
REQ-033 Back-to-back: a new grant may be issued in the first IDLE cycle after the fill; the minimum request-to-request spacing is 1 IDLE clock.
REQ-034 refresh_en=1 only in IDLE with no slot pending, or while downloading=1.
REQ-035 downloading=1: all cache valid bits clear each clock, no new request is issued, and an in-flight transaction completes without filling the cache.
REQ-036 If sdram_ack and data_rdy are both 1 in the same cycle in WAIT_ACK, the state moves to WAIT_DATA and that data_rdy is ignored.

Reset
REQ-037 On rst=1 the block asynchronously enters IDLE and sets: sdram_req=0, sdram_addr=0, all cache valid=0, tags=0, data=0, RR pointer=SLOTS-1, refresh_en=1, slot_ok=0.
REQ-038 A reset asserted mid-transaction aborts the transaction; the late data_rdy that follows is ignored in IDLE.

Verification
REQ-039 SLOTS=2, DW32=2'b00, OFFSETS={22'h14000,0}; slot1 cs, addr=0x0003 -> sdram_addr=0x14001; data_read=0x1234_ABCD -> slot1 dout=0x000000AB, ok one clock after data_rdy.
REQ-040 RR=0, slots 0 and 2 pending together -> slot 0 is granted first; RR=1, last grant=0, slots 0 and 2 pending -> slot 2 is granted.
REQ-041 Repeated read of the same address after a fill -> ok with no new sdram_req; refresh_en=1 throughout.
REQ-042 Address changed during WAIT_DATA -> ok stays 0 and a second request is issued with the new address.
REQ-043 downloading pulsed after a fill -> all ok=0 and the next read re-fetches from SDRAM.
REQ-044 rst asserted in WAIT_ACK -> sdram_req=0 immediately; data_rdy two clocks later does not set any ok.
